mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 single-bit mux output channel among 8 requesters.
- Each requester i drives its data bit on i[k].
- The arbiter grants one owner at a time, drives the mux select, and gates the shared output Y.
- A hold limit bounds ownership so no requester starves; it sits between the requester bank and the shared output line.

---
 rtl/mux8_rr_arbiter_pkg.sv | 36 +++
 rtl/mux8by1.sv | 24 ++
 rtl/mux8_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and the rotating-priority pick helper
// for the 8-requester mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan from the highest index offset down so the candidate nearest to
    // start is the last one written and therefore wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   start);
        pick_t            res;
        logic [SEL_W-1:0] k;
        res.found = 1'b0;
        res.idx   = {SEL_W{1'b0}};
        for (int n = NUM_REQ - 1; n >= 0; n--) begin
            k = start + SEL_W'(n);
            if (req[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux8by1.sv
// Plain 8:1 single-bit multiplexer: y = i[s].
module mux8by1 (
    input  logic [7:0] i,
    input  logic [2:0] s,
    output logic       y
);

    // Select one data bit by index.
    always_comb begin
        y = 1'b0;
        case (s)
            3'd0:    y = i[0];
            3'd1:    y = i[1];
            3'd2:    y = i[2];
            3'd3:    y = i[3];
            3'd4:    y = i[4];
            3'd5:    y = i[5];
            3'd6:    y = i[6];
            3'd7:    y = i[7];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux output with a hold limit.
// Optional MUX8_ARB_LOCK_EN adds a lock input that suppresses preemption.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] i,
`ifdef MUX8_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   s,
    output logic               busy,
    output logic               Y
);

    localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

    state_t             state_r, state_n;
    logic [NUM_REQ-1:0] gnt_r, gnt_n;
    logic [SEL_W-1:0]   s_r, s_n;
    logic               busy_r, busy_n;
    logic [SEL_W-1:0]   ptr_r, ptr_n;
    logic [HOLD_W-1:0]  cnt_r, cnt_n;
    logic               lock_s;
    logic               owner_req_s;
    logic               mux_bit_s;
    pick_t              pick_s;

`ifdef MUX8_ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    // ptr always equals owner+1 while granted, so one scan from ptr with the
    // owner masked out serves both the idle pick and the hand-over pick.
    assign pick_s      = rr_pick(req & ~gnt_r, ptr_r);
    assign owner_req_s = |(req & gnt_r);

    // Next-state, grant and hold-counter decisions.
    always_comb begin
        state_n = state_r;
        gnt_n   = gnt_r;
        s_n     = s_r;
        busy_n  = busy_r;
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s.found) begin
                    state_n = ST_GRANT;
                    gnt_n   = 8'b0000_0001 << pick_s.idx;
                    s_n     = pick_s.idx;
                    busy_n  = 1'b1;
                    ptr_n   = pick_s.idx + 3'd1;
                    cnt_n   = {HOLD_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if ((!owner_req_s || (cnt_r == LIMIT && !lock_s)) && pick_s.found) begin
                    gnt_n = 8'b0000_0001 << pick_s.idx;
                    s_n   = pick_s.idx;
                    ptr_n = pick_s.idx + 3'd1;
                    cnt_n = {HOLD_W{1'b0}};
                end else if (!owner_req_s) begin
                    state_n = ST_IDLE;
                    gnt_n   = {NUM_REQ{1'b0}};
                    s_n     = {SEL_W{1'b0}};
                    busy_n  = 1'b0;
                    cnt_n   = {HOLD_W{1'b0}};
                end else if (!lock_s && cnt_r != LIMIT) begin
                    cnt_n = cnt_r + HOLD_W'(1);
                end else begin
                    cnt_n = cnt_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = {NUM_REQ{1'b0}};
                s_n     = {SEL_W{1'b0}};
                busy_n  = 1'b0;
                cnt_n   = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NUM_REQ{1'b0}};
            s_r     <= {SEL_W{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= {SEL_W{1'b0}};
            cnt_r   <= {HOLD_W{1'b0}};
        end else begin
            state_r <= state_n;
            gnt_r   <= gnt_n;
            s_r     <= s_n;
            busy_r  <= busy_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
        end
    end

    mux8by1 u_mux (
        .i (i),
        .s (s_r),
        .y (mux_bit_s)
    );

    assign gnt  = gnt_r;
    assign s    = s_r;
    assign busy = busy_r;
    assign Y    = busy_r & mux_bit_s;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus random
// traffic compared against an owner/pointer/counter reference model.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] i;
    logic       lock_v;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       Y;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner index or -1 when idle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .i    (i),
`ifdef MUX8_ARB_LOCK_EN
        .lock (lock_v),
`endif
        .gnt  (gnt),
        .s    (s),
        .busy (busy),
        .Y    (Y)
    );

    function automatic int scan(input logic [7:0] r, input int start, input int excl);
        for (int n = 0; n < 8; n++) begin
            int k;
            k = (start + n) % 8;
            if (k != excl && r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [7:0] r_req, input logic r_lock);
        int w;
        if (r_rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            w = scan(r_req, m_ptr, -1);
            if (w >= 0) begin m_owner = w; m_cnt = 0; m_ptr = (w + 1) % 8; end
        end else begin
            w = scan(r_req, (m_owner + 1) % 8, m_owner);
            if (!r_req[m_owner]) begin
                if (w >= 0) begin m_owner = w; m_cnt = 0; m_ptr = (w + 1) % 8; end
                else begin m_owner = -1; m_cnt = 0; end
            end else if (m_cnt == MAX_HOLD - 1 && w >= 0 && !r_lock) begin
                m_owner = w; m_cnt = 0; m_ptr = (w + 1) % 8;
            end else if (!r_lock && m_cnt < MAX_HOLD - 1) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0] e_gnt;
        logic [7:0] e_s;
        logic [7:0] e_y;
        e_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        e_s   = (m_owner < 0) ? 8'h00 : 8'(m_owner);
        e_y   = (m_owner < 0) ? 8'h00 : {7'd0, i[m_owner]};
        chk("gnt", gnt, e_gnt);
        chk("s", {5'd0, s}, e_s);
        chk("busy", {7'd0, busy}, {7'd0, (m_owner >= 0)});
        chk("Y", {7'd0, Y}, e_y);
    endtask

    // Drive inputs, clock one edge, advance the model and compare.
    task automatic cycle(input logic r_rst, input logic [7:0] r_req, input logic [7:0] r_i,
                         input logic r_lock);
        rst = r_rst; req = r_req; i = r_i; lock_v = r_lock;
        @(posedge clk);
        model_edge(r_rst, r_req, r_lock);
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; i = 8'h00; lock_v = 1'b0;

        // Reset and idle
        cycle(1'b1, 8'h00, 8'hFF, 1'b0);
        cycle(1'b1, 8'hFF, 8'hFF, 1'b0);
        chk("rst_gnt", gnt, 8'h00);
        for (int n = 0; n < 5; n++) cycle(1'b0, 8'h00, 8'hFF, 1'b0);
        chk("idle_busy", {7'd0, busy}, 8'h00);

        // Release hand-over and pointer wrap
        cycle(1'b0, 8'h81, 8'h00, 1'b0);
        chk("first_gnt", gnt, 8'h01);
        cycle(1'b0, 8'h80, 8'h00, 1'b0);
        chk("handover_gnt", gnt, 8'h80);
        chk("handover_s", {5'd0, s}, 8'h07);
        cycle(1'b0, 8'h00, 8'h00, 1'b0);
        chk("release_busy", {7'd0, busy}, 8'h00);
        cycle(1'b0, 8'h01, 8'h00, 1'b0);
        chk("wrap_gnt", gnt, 8'h01);

        // Hold limit rotation between owners 1 and 2
        cycle(1'b1, 8'h00, 8'h02, 1'b0);
        for (int n = 0; n < MAX_HOLD; n++) begin
            cycle(1'b0, 8'h06, 8'h02, 1'b0);
            chk("hold1_gnt", gnt, 8'h02);
            chk("hold1_y", {7'd0, Y}, 8'h01);
        end
        for (int n = 0; n < MAX_HOLD; n++) begin
            cycle(1'b0, 8'h06, 8'h02, 1'b0);
            chk("hold2_gnt", gnt, 8'h04);
            chk("hold2_y", {7'd0, Y}, 8'h00);
        end
        cycle(1'b0, 8'h06, 8'h02, 1'b0);
        chk("hold_back_gnt", gnt, 8'h02);

        // Sole requester never preempted
        for (int n = 0; n < 100; n++) cycle(1'b0, 8'h10, 8'h10, 1'b0);
        chk("sole_gnt", gnt, 8'h10);

        // Reset mid-grant
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        cycle(1'b0, 8'h20, 8'h20, 1'b0);
        chk("own5_gnt", gnt, 8'h20);
        cycle(1'b1, 8'h21, 8'h20, 1'b0);
        chk("midrst_gnt", gnt, 8'h00);
        cycle(1'b0, 8'h21, 8'h20, 1'b0);
        chk("post_rst_gnt", gnt, 8'h01);

`ifdef MUX8_ARB_LOCK_EN
        // Lock suppresses preemption at the limit
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        for (int n = 0; n < 20; n++) cycle(1'b0, 8'h08, 8'h00, 1'b0);
        for (int n = 0; n < 40; n++) cycle(1'b0, 8'h0C, 8'h00, 1'b1);
        chk("lock_gnt", gnt, 8'h08);
        cycle(1'b0, 8'h0C, 8'h00, 1'b0);
        chk("unlock_gnt", gnt, 8'h04);
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            cycle(($urandom_range(0, 60) == 0), r, 8'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
